sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
Single-clock, parametrised FIFO for buffering 65-bit flit/word traffic between blocks in one clock domain. It is the same-domain successor to the dual-clock FIFO. Over that block it adds:
- occupancy count
- programmable almost-full and almost-empty thresholds
- selectable read mode: registered read, or first-word-fall-through (FWFT)
No pointer synchronisers; pointer comparison is exact and has zero latency.

Parameters:
- DATA_W, 65, width of one stored word.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (2 to 1024).
- FWFT, 0, read mode. 0 = registered read, data appears one cycle after the pop. 1 = head word is visible on rd_data while not empty.
- AFULL_TH, DEPTH-1, almost_full asserts when level >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1, almost_empty asserts when level <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high, sampled on rising clk.
- wr_fire  in  1  write request.
- wr_data  in  DATA_W  write data.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AFULL_TH.
- rd_fire  in  1  read/pop request.
- rd_data  out  DATA_W  read data.
- empty  out  1  level == 0.
- almost_empty  out  1  level <= AEMPTY_TH.
- level  out  ADDR_W+1  number of stored words, 0..DEPTH.

Behaviour:
- State registers:
  - wptr and rptr, binary, ADDR_W+1 bits each, wrapping modulo 2**(ADDR_W+1).
  - level = wptr - rptr, truncated to ADDR_W+1 bits.
  - Storage index = pointer[ADDR_W-1:0].
- Reset (rst=1 at a clk edge):
  - wptr, rptr and the rd_data register go to 0.
  - Resulting outputs: empty=1, full=0, level=0, almost_empty=1, almost_full=0 (AFULL_TH>=1).
  - Memory contents are not reset.
  - Reset mid-operation discards all contents.
  - rst has priority over wr_fire and rd_fire in the same cycle.
- Write acceptance:
  - A write is accepted iff wr_fire && !full, evaluated on pre-edge state.
  - An accepted write stores wr_data at wptr and increments wptr.
  - wr_fire while full is ignored: no state change, no overwrite.
- Read acceptance:
  - A read is accepted iff rd_fire && !empty, evaluated on pre-edge state.
  - An accepted read increments rptr.
  - rd_fire while empty is ignored.
- Simultaneous write and read, both accepted: level is unchanged.
  - Full + wr_fire + rd_fire: read accepted, write rejected. No same-cycle bypass; level goes to DEPTH-1.
  - Empty + wr_fire + rd_fire: write accepted, read rejected; level goes to 1.
- FWFT=0 read data:
  - On an accepted read, rd_data is registered from mem[rptr] and valid in the cycle after the pop edge.
  - Otherwise rd_data holds its last value. Reset value is 0.
- FWFT=1 read data:
  - rd_data = mem[rptr] combinationally when !empty; rd_data = 0 when empty.
  - A word written at edge N is visible on rd_data in cycle N+1 if it is the head.
  - A pop at edge N presents the next word in cycle N+1.
- Flags:
  - full, empty, almost_full, almost_empty and level are decoded combinationally from the registered pointers only.
  - They are therefore glitch-free relative to clk and do not depend combinationally on wr_fire or rd_fire.
  - Flag update latency is one edge after the accepted operation.
- Wrap-around: pointers wrap naturally. Pointer MSB inequality with equal low bits means full.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds three ports.
  - err_clr, in, 1: clear request.
  - overflow, out, 1: sticky; set on any cycle with wr_fire && full.
  - underflow, out, 1: sticky; set on any cycle with rd_fire && empty.
  - Both sticky flags are registered and visible the cycle after the offending edge.
  - Cleared by rst or err_clr. If set and clear coincide, set wins.
  - FIFO data path is unaffected.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_W (65) and ADDR_W (3)
  - a function returning DEPTH from ADDR_W
  - a level-width constant
  - read-mode constants FIFO_MODE_REG=0 and FIFO_MODE_FWFT=1
- One natural sub-module: fifo_ram, a simple dual-port array.
  - Synchronous write, asynchronous read, parametrised by DATA_W and ADDR_W.
- Pointer, flag and read-mode logic stays in sync_fifo_flex.

Test Plan:
- Reset then idle, DEPTH=8 -> empty=1, full=0, level=0, almost_empty=1, rd_data=0; rd_fire alone leaves all unchanged (with ERR_FLAGS_EN: underflow=1 next cycle).
- Fill: 8 writes 0x1..0x8 -> level 1..8, almost_full at level 7, full at 8. A 9th write of 0x9 is ignored; level stays 8.
- Drain with FWFT=0 -> rd_data 0x1..0x8, each one cycle after its pop. empty=1 after the 8th pop; rd_data then holds 0x8.
- FWFT=1, write 0xA5 at edge N -> rd_data=0xA5 and empty=0 in cycle N+1. After the pop, rd_data=0 and empty=1.
- Simultaneous ops:
  - at level 8, wr_fire+rd_fire -> level 7, head popped, new word dropped.
  - at level 0, wr_fire+rd_fire -> level 1.
  - at level 4 -> level stays 4, order preserved.
- Wrap: 20 interleaved write/read pairs of an incrementing pattern through DEPTH=8 -> output exactly equals input order. rst asserted mid-stream -> level=0 the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, depth helper and read-mode constants for sync_fifo_flex
package fifo_pkg;
    localparam int DATA_W_DEF = 65;
    localparam int ADDR_W_DEF = 3;
    localparam int LEVEL_W_DEF = ADDR_W_DEF + 1;
    localparam int FIFO_MODE_REG = 0;
    localparam int FIFO_MODE_FWFT = 1;
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port array, synchronous write, asynchronous read
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];
    // storage is never reset; only written words are ever read back
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with level, thresholds and registered/FWFT read.
// Optional sticky overflow/underflow flags under SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int FWFT      = FIFO_MODE_REG,
    parameter int AFULL_TH  = fifo_depth(ADDR_W) - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_fire,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_fire,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [ADDR_W:0]   level
);
    localparam logic [ADDR_W:0] LVL_DEPTH = (ADDR_W + 1)'(fifo_depth(ADDR_W));
    localparam logic [ADDR_W:0] LVL_AFULL = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] LVL_AEMPTY = (ADDR_W + 1)'(AEMPTY_TH);

    logic [ADDR_W:0]   wptr, rptr;
    logic              wr_ok, rd_ok;
    logic [DATA_W-1:0] ram_q;

    // flags come only from registered pointers, so they never see the fire inputs
    assign level        = wptr - rptr;
    assign empty        = wptr == rptr;
    assign full         = level == LVL_DEPTH;
    assign almost_full  = level >= LVL_AFULL;
    assign almost_empty = level <= LVL_AEMPTY;
    assign wr_ok        = wr_fire && !full;
    assign rd_ok        = rd_fire && !empty;

    // pointers advance on accepted operations; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end
    end

    fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rptr[ADDR_W-1:0]),
        .rdata (ram_q)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign rd_data = empty ? '0 : ram_q;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_q;
            // head word captured on pop, held otherwise
            always_ff @(posedge clk) begin
                if (rst) rd_q <= '0;
                else if (rd_ok) rd_q <= ram_q;
            end
            assign rd_data = rd_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // sticky error flags; a new violation outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_fire && full) || (overflow && !err_clr);
            underflow <= (rd_fire && empty) || (underflow && !err_clr);
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed checks of a registered-read and an FWFT instance driven in lockstep
module tb_sync_fifo_flex;
    logic        clk = 1'b0;
    logic        rst, wr_fire, rd_fire;
    logic [64:0] wr_data;
    logic        full_r, afull_r, empty_r, aempty_r;
    logic        full_f, afull_f, empty_f, aempty_f;
    logic [64:0] rd_r, rd_f;
    logic [3:0]  level_r, level_f;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic        err_clr, ovf_r, unf_r, ovf_f, unf_f;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .wr_fire(wr_fire), .wr_data(wr_data),
        .full(full_r), .almost_full(afull_r), .rd_fire(rd_fire), .rd_data(rd_r),
        .empty(empty_r), .almost_empty(aempty_r),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .err_clr(err_clr), .overflow(ovf_r), .underflow(unf_r),
`endif
        .level(level_r)
    );

    sync_fifo_flex #(.FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .wr_fire(wr_fire), .wr_data(wr_data),
        .full(full_f), .almost_full(afull_f), .rd_fire(rd_fire), .rd_data(rd_f),
        .empty(empty_f), .almost_empty(aempty_f),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .err_clr(err_clr), .overflow(ovf_f), .underflow(unf_f),
`endif
        .level(level_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_fire = 1'b0; rd_fire = 1'b0; wr_data = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        tick();
        rst = 1'b0;
        checks++; if ({empty_r, full_r, aempty_r, afull_r} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b need 1010", {empty_r, full_r, aempty_r, afull_r}); end
        checks++; if (level_r !== 4'd0) begin errors++; $display("FAIL reset_level got %0d need 0", level_r); end
        checks++; if (rd_r !== 65'h0 || rd_f !== 65'h0) begin errors++; $display("FAIL reset_rd_data got %h/%h need 0", rd_r, rd_f); end
        rd_fire = 1'b1;
        tick();
        rd_fire = 1'b0;
        checks++; if (level_r !== 4'd0 || empty_r !== 1'b1 || rd_r !== 65'h0) begin errors++; $display("FAIL empty_pop got lvl=%0d empty=%b rd=%h need 0/1/0", level_r, empty_r, rd_r); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++; if (unf_r !== 1'b1 || ovf_r !== 1'b0) begin errors++; $display("FAIL underflow_set got unf=%b ovf=%b need 1/0", unf_r, ovf_r); end
        err_clr = 1'b1; rd_fire = 1'b1;
        tick();
        rd_fire = 1'b0;
        checks++; if (unf_r !== 1'b1) begin errors++; $display("FAIL set_wins got %b need 1", unf_r); end
        tick();
        err_clr = 1'b0;
        checks++; if (unf_r !== 1'b0) begin errors++; $display("FAIL err_clr got %b need 0", unf_r); end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            wr_fire = 1'b1; wr_data = 65'(i);
            tick();
            checks++; if (level_r !== 4'(i)) begin errors++; $display("FAIL fill_level[%0d] got %0d need %0d", i, level_r, i); end
            checks++; if ({afull_r, full_r, aempty_r} !== {i >= 7, i == 8, i <= 1}) begin errors++; $display("FAIL fill_flags[%0d] got %b need %b", i, {afull_r, full_r, aempty_r}, {i >= 7, i == 8, i <= 1}); end
            checks++; if (rd_f !== 65'h1) begin errors++; $display("FAIL fill_fwft_head[%0d] got %h need 1", i, rd_f); end
        end
        wr_data = 65'h9;
        tick();
        wr_fire = 1'b0;
        checks++; if (level_r !== 4'd8 || full_r !== 1'b1) begin errors++; $display("FAIL overfill got lvl=%0d full=%b need 8/1", level_r, full_r); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++; if (ovf_r !== 1'b1) begin errors++; $display("FAIL overflow_set got %b need 1", ovf_r); end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            rd_fire = 1'b1;
            tick();
            checks++; if (rd_r !== 65'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h need %h", i, rd_r, 65'(i)); end
            checks++; if (level_r !== 4'(8 - i) || empty_r !== (i == 8)) begin errors++; $display("FAIL drain_level[%0d] got %0d/%b need %0d/%b", i, level_r, empty_r, 8 - i, i == 8); end
            checks++; if (rd_f !== ((i < 8) ? 65'(i + 1) : 65'h0)) begin errors++; $display("FAIL drain_fwft[%0d] got %h need %h", i, rd_f, (i < 8) ? 65'(i + 1) : 65'h0); end
        end
        rd_fire = 1'b0;
        tick();
        checks++; if (rd_r !== 65'h8) begin errors++; $display("FAIL drain_hold got %h need 8", rd_r); end
    endtask

    task automatic test_fwft();
        wr_fire = 1'b1; wr_data = 65'hA5;
        tick();
        wr_fire = 1'b0;
        checks++; if (rd_f !== 65'hA5 || empty_f !== 1'b0) begin errors++; $display("FAIL fwft_visible got %h/%b need a5/0", rd_f, empty_f); end
        rd_fire = 1'b1;
        tick();
        rd_fire = 1'b0;
        checks++; if (rd_f !== 65'h0 || empty_f !== 1'b1) begin errors++; $display("FAIL fwft_popped got %h/%b need 0/1", rd_f, empty_f); end
        checks++; if (rd_r !== 65'hA5) begin errors++; $display("FAIL reg_pop_a5 got %h need a5", rd_r); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) begin
            wr_fire = 1'b1; wr_data = 65'(8'h10 + i);
            tick();
        end
        wr_data = 65'hFF; rd_fire = 1'b1;
        tick();
        wr_fire = 1'b0;
        checks++; if (level_r !== 4'd7 || rd_r !== 65'h10) begin errors++; $display("FAIL simul_full got %0d/%h need 7/10", level_r, rd_r); end
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++; if (rd_r !== 65'(8'h10 + i)) begin errors++; $display("FAIL simul_full_drain[%0d] got %h need %h", i, rd_r, 65'(8'h10 + i)); end
        end
        rd_fire = 1'b0;
        checks++; if (empty_r !== 1'b1) begin errors++; $display("FAIL simul_full_empty got %b need 1", empty_r); end
        wr_fire = 1'b1; rd_fire = 1'b1; wr_data = 65'h30;
        tick();
        wr_fire = 1'b0; rd_fire = 1'b0;
        checks++; if (level_r !== 4'd1 || rd_r !== 65'h17 || rd_f !== 65'h30) begin errors++; $display("FAIL simul_empty got %0d/%h/%h need 1/17/30", level_r, rd_r, rd_f); end
        rd_fire = 1'b1;
        tick();
        rd_fire = 1'b0;
        checks++; if (rd_r !== 65'h30) begin errors++; $display("FAIL simul_empty_pop got %h need 30", rd_r); end
        for (int i = 0; i < 4; i++) begin
            wr_fire = 1'b1; wr_data = 65'(8'h40 + i);
            tick();
        end
        wr_data = 65'h44; rd_fire = 1'b1;
        tick();
        wr_fire = 1'b0;
        checks++; if (level_r !== 4'd4 || rd_r !== 65'h40) begin errors++; $display("FAIL simul_mid got %0d/%h need 4/40", level_r, rd_r); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (rd_r !== 65'(8'h40 + i)) begin errors++; $display("FAIL simul_mid_order[%0d] got %h need %h", i, rd_r, 65'(8'h40 + i)); end
        end
        rd_fire = 1'b0;
    endtask

    task automatic test_wrap();
        logic [64:0] pat;
        for (int i = 0; i < 20; i++) begin
            pat = {1'b1, 64'(i * 3 + 7)};
            wr_fire = 1'b1; wr_data = pat;
            tick();
            wr_fire = 1'b0;
            checks++; if (rd_f !== pat) begin errors++; $display("FAIL wrap_fwft[%0d] got %h need %h", i, rd_f, pat); end
            rd_fire = 1'b1;
            tick();
            rd_fire = 1'b0;
            checks++; if (rd_r !== pat || empty_r !== 1'b1) begin errors++; $display("FAIL wrap_reg[%0d] got %h/%b need %h/1", i, rd_r, empty_r, pat); end
        end
        for (int i = 0; i < 3; i++) begin
            wr_fire = 1'b1; wr_data = 65'(i);
            tick();
        end
        rst = 1'b1; rd_fire = 1'b1;
        tick();
        rst = 1'b0; wr_fire = 1'b0; rd_fire = 1'b0;
        checks++; if (level_r !== 4'd0 || empty_r !== 1'b1 || rd_r !== 65'h0) begin errors++; $display("FAIL mid_reset got %0d/%b/%h need 0/1/0", level_r, empty_r, rd_r); end
        checks++; if (level_f !== 4'd0 || rd_f !== 65'h0) begin errors++; $display("FAIL mid_reset_fwft got %0d/%h need 0/0", level_f, rd_f); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_fwft();
        test_simultaneous();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
